// File: rtl/fetch_mem_responder_pkg.sv
// Shared constants for the instruction-fetch memory responder:
// FSM state encoding, boolean literals, data width and byte-lane indices.
package fetch_mem_responder_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam int DATA_WIDTH = 32;
   localparam int BYTE_WIDTH = 8;

   localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

   // Byte-lane index within the assembled word (lane 0 = bits 7:0).
   localparam logic [1:0] LANE_0 = 2'd0;
   localparam logic [1:0] LANE_1 = 2'd1;
   localparam logic [1:0] LANE_2 = 2'd2;
   localparam logic [1:0] LANE_3 = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } state_t;

endpackage

// File: rtl/fetch_mem_responder_fetch_word_buf.sv
// One-entry fetched-word buffer {valid, tag, word}.
// Only instantiated when FETCH_WORD_BUF_EN is defined.
// Invalidate beats both a hit and a same-edge load.
module fetch_word_buf
   import fetch_mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_rdy,
   input  logic                  i_invalidate,
   input  logic [ADDR_WIDTH-1:0] i_lookup_addr,
   input  logic                  i_load,
   input  logic [ADDR_WIDTH-1:0] i_load_tag,
   input  logic [DATA_WIDTH-1:0] i_load_word,
   output logic                  o_hit,
   output logic [DATA_WIDTH-1:0] o_word
);

   logic                  r_valid;
   logic [ADDR_WIDTH-1:0] r_tag;
   logic [DATA_WIDTH-1:0] r_word;

   // Entry update: invalidate clears, a completed RAM fetch refills.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= FALSE;
         r_tag   <= '0;
         r_word  <= ZERO_DATA;
      end else if (i_rdy) begin
         if (i_load) begin
            r_tag  <= i_load_tag;
            r_word <= i_load_word;
         end
         if (i_invalidate) begin
            r_valid <= FALSE;
         end else if (i_load) begin
            r_valid <= TRUE;
         end
      end
   end

   // Hit is suppressed by a coincident invalidate so the request becomes a miss.
   always_comb begin
      o_hit  = r_valid && !i_invalidate && (r_tag == i_lookup_addr);
      o_word = r_word;
   end

endmodule

// File: rtl/fetch_mem_responder.sv
// Memory-side responder for the instruction-fetch handshake. Reads four
// consecutive bytes from a byte-wide synchronous RAM starting at the
// requested byte address (wrapping modulo 2^ADDR_WIDTH) and returns them
// little-endian with a one-cycle out_rdy pulse. Read-only.
// Optional feature macro: FETCH_WORD_BUF_EN adds a one-entry word buffer
// that answers a repeated address in one cycle without touching RAM.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for in_req; may be showing the previous out_rdy
// ST_READ | stepping mem_a through base..base+3, capturing one lane/edge
module fetch_mem_responder
   import fetch_mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int RAM_ADDR_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      in_req,
   input  logic [ADDR_WIDTH-1:0]     in_addr,
   input  logic                      in_invalidate,
   output logic                      out_rdy,
   output logic [DATA_WIDTH-1:0]     out_data,
   output logic                      out_busy,
   output logic [RAM_ADDR_WIDTH-1:0] mem_a,
   input  logic [BYTE_WIDTH-1:0]     mem_din,
   output logic                      mem_wr
);

   state_t                    r_state;
   logic [1:0]                r_cnt;
   logic [ADDR_WIDTH-1:0]     r_base;
   logic [23:0]               r_asm;
   logic                      r_out_rdy;
   logic [DATA_WIDTH-1:0]     r_out_data;
   logic                      r_out_busy;
   logic [RAM_ADDR_WIDTH-1:0] r_mem_a;

   state_t                    w_state_nx;
   logic [1:0]                w_cnt_nx;
   logic [ADDR_WIDTH-1:0]     w_base_nx;
   logic [23:0]               w_asm_nx;
   logic                      w_rdy_nx;
   logic [DATA_WIDTH-1:0]     w_data_nx;
   logic                      w_busy_nx;
   logic [RAM_ADDR_WIDTH-1:0] w_mem_a_nx;
   logic                      w_load;
   logic                      w_hit;
   logic [DATA_WIDTH-1:0]     w_buf_word;
   logic [ADDR_WIDTH-1:0]     w_next_addr;

   // Address of the byte after the one being captured; wraps naturally.
   assign w_next_addr = r_base + ADDR_WIDTH'(r_cnt) + ADDR_WIDTH'(1);

`ifdef FETCH_WORD_BUF_EN
   fetch_word_buf #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_word_buf (
      .clk           (clk),
      .rst           (rst),
      .i_rdy         (rdy),
      .i_invalidate  (in_invalidate),
      .i_lookup_addr (in_addr),
      .i_load        (w_load),
      .i_load_tag    (r_base),
      .i_load_word   (w_data_nx),
      .o_hit         (w_hit),
      .o_word        (w_buf_word)
   );
`else
   logic w_unused_buf;
   assign w_hit        = FALSE;
   assign w_buf_word   = ZERO_DATA;
   assign w_unused_buf = in_invalidate ^ w_load;
`endif

   // State and datapath register; everything holds while rdy is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= LANE_0;
         r_base     <= '0;
         r_asm      <= '0;
         r_out_rdy  <= FALSE;
         r_out_data <= ZERO_DATA;
         r_out_busy <= FALSE;
         r_mem_a    <= '0;
      end else if (rdy) begin
         r_state    <= w_state_nx;
         r_cnt      <= w_cnt_nx;
         r_base     <= w_base_nx;
         r_asm      <= w_asm_nx;
         r_out_rdy  <= w_rdy_nx;
         r_out_data <= w_data_nx;
         r_out_busy <= w_busy_nx;
         r_mem_a    <= w_mem_a_nx;
      end
   end

   // Next-state and output decode; out_rdy is a pulse so it defaults low.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_base_nx  = r_base;
      w_asm_nx   = r_asm;
      w_mem_a_nx = r_mem_a;
      w_data_nx  = r_out_data;
      w_rdy_nx   = FALSE;
      w_busy_nx  = FALSE;
      w_load     = FALSE;
      case (r_state)
         ST_IDLE: begin
            if (in_req) begin
               w_busy_nx = TRUE;
               if (w_hit) begin
                  w_data_nx = w_buf_word;
                  w_rdy_nx  = TRUE;
               end else begin
                  w_state_nx = ST_READ;
                  w_base_nx  = in_addr;
                  w_mem_a_nx = in_addr[RAM_ADDR_WIDTH-1:0];
                  w_cnt_nx   = LANE_0;
               end
            end
         end
         ST_READ: begin
            w_busy_nx = TRUE;
            if (r_cnt == LANE_3) begin
               // Top lane comes straight from the RAM port, saving a cycle.
               w_data_nx  = {mem_din, r_asm};
               w_rdy_nx   = TRUE;
               w_load     = TRUE;
               w_state_nx = ST_IDLE;
            end else begin
               case (r_cnt)
                  LANE_0:  w_asm_nx[7:0]   = mem_din;
                  LANE_1:  w_asm_nx[15:8]  = mem_din;
                  LANE_2:  w_asm_nx[23:16] = mem_din;
                  default: ;
               endcase
               w_mem_a_nx = w_next_addr[RAM_ADDR_WIDTH-1:0];
               w_cnt_nx   = r_cnt + 2'd1;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   assign out_rdy  = r_out_rdy;
   assign out_data = r_out_data;
   assign out_busy = r_out_busy;
   assign mem_a    = r_mem_a;
   assign mem_wr   = FALSE;

endmodule

// File: tb/tb_fetch_mem_responder.sv
// Self-checking bench for fetch_mem_responder. A transaction-level model
// (edge counting since acceptance, word = four RAM bytes at base+k) is
// compared against the DUT on every falling edge; directed sequences pin
// literal values and latencies, then a randomized phase exercises stalls,
// overlapping requests and (with FETCH_WORD_BUF_EN) buffer hits.
module tb_fetch_mem_responder;

`ifdef FETCH_WORD_BUF_EN
   localparam bit BUF_EN = 1'b1;
`else
   localparam bit BUF_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        in_req;
   logic [31:0] in_addr;
   logic        in_invalidate;
   logic        out_rdy;
   logic [31:0] out_data;
   logic        out_busy;
   logic [31:0] mem_a;
   logic [7:0]  mem_din;
   logic        mem_wr;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_mem_responder #(
      .ADDR_WIDTH     (32),
      .RAM_ADDR_WIDTH (32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .in_req        (in_req),
      .in_addr       (in_addr),
      .in_invalidate (in_invalidate),
      .out_rdy       (out_rdy),
      .out_data      (out_data),
      .out_busy      (out_busy),
      .mem_a         (mem_a),
      .mem_din       (mem_din),
      .mem_wr        (mem_wr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM contents: a few pinned bytes, everything else a fixed hash.
   function automatic logic [7:0] ram_byte(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 8'h13;
         32'h0000_0101: return 8'h00;
         32'h0000_0102: return 8'h00;
         32'h0000_0103: return 8'h93;
         32'hFFFF_FFFE: return 8'hAA;
         32'hFFFF_FFFF: return 8'hBB;
         32'h0000_0000: return 8'hCC;
         32'h0000_0001: return 8'hDD;
         default:       return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
      endcase
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] b);
      return {ram_byte(b + 32'd3), ram_byte(b + 32'd2),
              ram_byte(b + 32'd1), ram_byte(b)};
   endfunction

   // Byte-wide RAM: data for the presented address is sampled on the next edge.
   assign mem_din = ram_byte(mem_a);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit          m_rdyo  = 0;
   bit          m_busy  = 0;
   logic [31:0] m_data  = '0;
   logic [31:0] m_mema  = '0;
   bit          m_inread = 0;
   int          m_k     = 0;
   logic [31:0] m_base  = '0;
   bit          m_bv    = 0;
   logic [31:0] m_btag  = '0;
   logic [31:0] m_bword = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_rdyo = 0; m_busy = 0; m_data = '0; m_mema = '0;
         m_inread = 0; m_k = 0; m_base = '0; m_bv = 0;
      end else if (rdy) begin
         m_rdyo = 0;
         if (m_inread) begin
            m_k++;
            if (m_k == 4) begin
               m_data   = word_at(m_base);
               m_rdyo   = 1;
               m_inread = 0;
               m_bv     = 1;
               m_btag   = m_base;
               m_bword  = m_data;
            end else begin
               m_mema = m_base + 32'(m_k);
            end
         end else if (in_req) begin
            m_busy = 1;
            if (BUF_EN && m_bv && m_btag == in_addr && !in_invalidate) begin
               m_data = m_bword;
               m_rdyo = 1;
            end else begin
               m_inread = 1;
               m_k      = 0;
               m_base   = in_addr;
               m_mema   = in_addr;
            end
         end else begin
            m_busy = 0;
         end
         if (in_invalidate) m_bv = 0;
      end
   end

   // Compare process: outputs are defined on every cycle.
   always @(negedge clk) begin
      check("model_out_rdy",  {31'd0, out_rdy},  {31'd0, m_rdyo});
      check("model_out_busy", {31'd0, out_busy}, {31'd0, m_busy});
      check("model_out_data", out_data, m_data);
      check("model_mem_a",    mem_a,    m_mema);
      check("mem_wr_low",     {31'd0, mem_wr},   32'd0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full RAM fetch with literal address/latency pins; invalidate on the
   // request edge forces a miss in either build.
   task automatic fetch_pinned(input logic [31:0] a, input logic [31:0] exp, input int stall);
      int cyc;
      cyc = 0;
      in_req = 1; in_addr = a; in_invalidate = 1;
      tick();
      in_req = 0; in_addr = $urandom; in_invalidate = 0;
      check("accept_busy", {31'd0, out_busy}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         check("mem_a_seq", mem_a, a + 32'(k));
         if (k == 2) begin
            for (int s = 0; s < stall; s++) begin
               rdy = 0;
               tick();
               cyc++;
               check("mem_a_stall", mem_a, a + 32'd2);
               check("stall_no_rdy", {31'd0, out_rdy}, 32'd0);
            end
            rdy = 1;
         end
         tick();
         cyc++;
      end
      check("ready_pulse", {31'd0, out_rdy}, 32'd1);
      check("latency", 32'(cyc), 32'(4 + stall));
      check("word", out_data, exp);
      check("busy_in_pulse", {31'd0, out_busy}, 32'd1);
      tick();
      check("ready_clear", {31'd0, out_rdy}, 32'd0);
      check("busy_clear", {31'd0, out_busy}, 32'd0);
      check("data_hold", out_data, exp);
   endtask

   function automatic logic [31:0] pick_addr();
      case ($urandom % 5)
         0: return 32'h0000_0100;
         1: return 32'hFFFF_FFFE;
         2: return 32'h0000_0200;
         3: return 32'h1234_5677;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] held_a;
      bit          seen;
      rst = 0; rdy = 1; in_req = 0; in_addr = '0; in_invalidate = 0;
      repeat (3) tick();
      check("reset_out_data", out_data, 32'h0);
      check("reset_mem_a", mem_a, 32'h0);
      check("reset_out_rdy", {31'd0, out_rdy}, 32'd0);
      rst = 1;
      tick();

      // Basic read, wrap-around, stalled read.
      fetch_pinned(32'h0000_0100, 32'h9300_0013, 0);
      fetch_pinned(32'hFFFF_FFFE, 32'hDDCC_BBAA, 0);
      fetch_pinned(32'h0000_0100, 32'h9300_0013, 3);

      // Buffer hit: one-cycle answer without moving mem_a.
      if (BUF_EN) begin
         held_a = mem_a;
         in_req = 1; in_addr = 32'h0000_0100;
         tick();
         in_req = 0;
         check("hit_rdy", {31'd0, out_rdy}, 32'd1);
         check("hit_data", out_data, 32'h9300_0013);
         check("hit_mem_a", mem_a, 32'h0000_0103);
         check("hit_mem_a_held", mem_a, held_a);
         check("hit_busy", {31'd0, out_busy}, 32'd1);
         tick();
         check("hit_busy_clear", {31'd0, out_busy}, 32'd0);
      end
      // Repeat with invalidate: full four-cycle read.
      fetch_pinned(32'h0000_0100, 32'h9300_0013, 0);

      // Overlap and back-to-back.
      in_req = 1; in_addr = 32'h0000_0200; in_invalidate = 1;
      tick();
      in_req = 0; in_invalidate = 0;
      tick();
      in_req = 1; in_addr = 32'h0000_0300;
      tick();
      in_req = 0;
      check("overlap_ignored_mem_a", mem_a, 32'h0000_0202);
      tick();
      tick();
      check("b2b_first_rdy", {31'd0, out_rdy}, 32'd1);
      check("b2b_first_data", out_data, word_at(32'h0000_0200));
      in_req = 1; in_addr = 32'h1234_5677; in_invalidate = 1;
      tick();
      in_req = 0; in_invalidate = 0;
      check("b2b_second_mem_a", mem_a, 32'h1234_5677);
      check("b2b_rdy_cleared", {31'd0, out_rdy}, 32'd0);
      check("b2b_busy", {31'd0, out_busy}, 32'd1);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         seen = out_rdy;
      end
      check("b2b_second_done", {31'd0, seen}, 32'd1);
      check("b2b_second_data", out_data, word_at(32'h1234_5677));
      tick();

      // Reset in the middle of a read.
      in_req = 1; in_addr = 32'h0000_0100; in_invalidate = 1;
      tick();
      in_req = 0; in_invalidate = 0;
      tick();
      tick();
      rst = 0;
      #1;
      check("rst_async_rdy", {31'd0, out_rdy}, 32'd0);
      check("rst_async_busy", {31'd0, out_busy}, 32'd0);
      check("rst_async_mem_a", mem_a, 32'h0);
      check("rst_async_data", out_data, 32'h0);
      tick();
      tick();
      rst = 1;
      tick();
      tick();
      check("rst_no_stale_rdy", {31'd0, out_rdy}, 32'd0);
      fetch_pinned(32'h0000_0100, 32'h9300_0013, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 500; i++) begin
         rdy           = ($urandom % 4) != 0;
         in_req        = ($urandom % 3) == 0;
         in_addr       = pick_addr();
         in_invalidate = ($urandom % 8) == 0;
         tick();
      end
      rdy = 1; in_req = 0; in_invalidate = 0;
      repeat (10) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
